// File: rtl/block_serial_sched_if.sv
// Handshake bundle between block requesters, the serial scheduler and the
// downstream byte consumer.
interface block_serial_sched_if #(
  parameter int NREQ  = 3,
  parameter int NCOEF = 64,
  parameter int DW    = 8,
  parameter int SRCW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ*NCOEF*DW-1:0] req_data;
  logic                     sout_valid;
  logic                     sout_ready;
  logic [DW-1:0]            sout_data;
  logic                     sout_last;
  logic [SRCW-1:0]          sout_src;
  logic                     busy;

  // slave: the scheduler; master: requesters plus the downstream consumer
  modport slave (
    input  req_valid, req_data, sout_ready,
    output req_ready, sout_valid, sout_data, sout_last, sout_src, busy
  );
  modport master (
    output req_valid, req_data, sout_ready,
    input  req_ready, sout_valid, sout_data, sout_last, sout_src, busy
  );
endinterface

// File: rtl/block_serial_sched.sv
// Round-robin block arbiter: captures one 64-byte block per grant and
// streams it out byte-serially, mapping the 8'hFF marker to 8'h00.
module block_serial_sched #(
  parameter int NREQ  = 3,
  parameter int NCOEF = 64,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  block_serial_sched_if.slave bus
);
  localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(NCOEF);
  localparam logic [CW-1:0]   LAST   = CW'(NCOEF - 1);
  localparam logic [DW-1:0]   MINUS1 = '1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state;
  logic [CW-1:0]              cnt;
  logic [SRCW-1:0]            rr_ptr;
  logic [SRCW-1:0]            src;
  logic [NCOEF-1:0][DW-1:0]   blk_buf;

  logic [SRCW-1:0]            gnt_idx;
  logic [SRCW-1:0]            scan;
  logic                       gnt_any;
  logic [NREQ-1:0]            gnt_oh;
  logic [DW-1:0]              cur_byte;

  // Walk offsets from farthest to nearest so the first set bit after rr_ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      scan = SRCW'((int'(rr_ptr) + k) % NREQ);
      if (bus.req_valid[scan]) begin
        gnt_idx = scan;
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (state == IDLE && gnt_any && !rst) gnt_oh[gnt_idx] = 1'b1;
  end

  assign cur_byte       = blk_buf[cnt];
  assign bus.req_ready  = gnt_oh;
  assign bus.sout_valid = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.sout_data  = (state == SEND && cur_byte != MINUS1) ? cur_byte : '0;
  assign bus.sout_last  = (state == SEND) && (cnt == LAST);
  assign bus.sout_src   = src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= SRCW'(NREQ - 1);
      src    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          state  <= SEND;
          rr_ptr <= gnt_idx;
          src    <= gnt_idx;
          cnt    <= '0;
        end
        SEND: if (bus.sout_ready) begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Block storage is never read outside SEND, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_any)
      blk_buf <= bus.req_data[int'(gnt_idx)*NCOEF*DW +: NCOEF*DW];
  end
endmodule

// File: tb/tb_block_serial_sched.sv
// Directed bench for block_serial_sched: grant order, byte stream, marker
// substitution, backpressure and mid-block reset.
module tb_block_serial_sched;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  logic [7:0] blk [NREQ][64];
  logic [7:0] rx  [64];

  block_serial_sched_if #(.NREQ(NREQ)) bus ();
  block_serial_sched #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 64; n++)
        bus.req_data[(i*64+n)*8 +: 8] = blk[i][n];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(output logic [2:0] g, output int gc);
    int t = 0;
    #1;
    while (bus.req_ready == 0 && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    chk("grant_seen", {31'b0, bus.req_ready != 0}, 1);
    g  = bus.req_ready;
    gc = cyc;
  endtask

  task automatic recv(input string tag, input int src, input bit alt,
                      input logic [2:0] nv, output int nc);
    int n = 0;
    logic [7:0] e;
    nc = 0;
    while (n < 64 && nc < 400) begin
      @(negedge clk);
      nc++;
      if (nc == 1) begin
        chk({tag, "_rdy_send"}, 32'(bus.req_ready), 0);
        bus.req_valid = nv;
      end
      e = (blk[src][n] == 8'hFF) ? 8'h00 : blk[src][n];
      chk({tag, "_valid"}, 32'(bus.sout_valid), 1);
      chk({tag, "_busy"},  32'(bus.busy), 1);
      chk({tag, "_data"},  32'(bus.sout_data), 32'(e));
      chk({tag, "_last"},  32'(bus.sout_last), 32'(n == 63));
      chk({tag, "_src"},   32'(bus.sout_src), 32'(src));
      rx[n] = bus.sout_data;
      bus.sout_ready = alt ? nc[0] : 1'b1;
      if (bus.sout_ready) n++;
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  logic [2:0] g;
  int gc, prev, nc;
  int order [4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.sout_ready = 1'b0;
    for (int n = 0; n < 64; n++) begin
      blk[0][n] = 8'(n);
      blk[1][n] = 8'(8'h40 + n);
      blk[2][n] = 8'(n) ^ 8'h55;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_valid", 32'(bus.sout_valid), 0);
    chk("rst_data",  32'(bus.sout_data), 0);
    chk("rst_last",  32'(bus.sout_last), 0);
    chk("rst_src",   32'(bus.sout_src), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    rst = 1'b0;
    bus.sout_ready = 1'b1;

    // single block, byte n = n
    @(negedge clk);
    bus.req_valid = 3'b001;
    wait_grant(g, gc);
    chk("t1_grant", 32'(g), 32'h1);
    recv("t1", 0, 1'b0, 3'b000, nc);
    chk("t1_cycles", nc, 64);
    @(negedge clk);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_idle_valid", 32'(bus.sout_valid), 0);

    // minus-one substitution
    for (int n = 0; n < 64; n++) blk[0][n] = 8'hFF;
    blk[0][5]  = 8'h7F;
    blk[0][63] = 8'hFE;
    bus.req_valid = 3'b001;
    wait_grant(g, gc);
    chk("t2_grant", 32'(g), 32'h1);
    recv("t2", 0, 1'b0, 3'b000, nc);
    chk("t2_rx0",  32'(rx[0]),  32'h00);
    chk("t2_rx5",  32'(rx[5]),  32'h7F);
    chk("t2_rx10", 32'(rx[10]), 32'h00);
    chk("t2_rx63", 32'(rx[63]), 32'hFE);

    // round-robin with all three held valid
    pulse_rst();
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 64; n++) blk[i][n] = 8'(i + 1);
    bus.req_valid = 3'b111;
    prev = 0;
    for (int b = 0; b < 4; b++) begin
      wait_grant(g, gc);
      chk("t3_grant", 32'(g), 32'(1 << order[b]));
      chk("t3_gap_valid", 32'(bus.sout_valid), 0);
      if (b > 0) chk("t3_spacing", gc - prev, 65);
      prev = gc;
      recv("t3", order[b], 1'b0, (b == 3) ? 3'b000 : 3'b111, nc);
    end

    // backpressure: ready alternates 1,0 during SEND
    for (int n = 0; n < 64; n++) blk[1][n] = 8'(8'h40 + n);
    @(negedge clk);
    bus.req_valid = 3'b010;
    wait_grant(g, gc);
    chk("t4_grant", 32'(g), 32'h2);
    recv("t4", 1, 1'b1, 3'b000, nc);
    chk("t4_cycles", nc, 127);
    bus.sout_ready = 1'b1;

    // reset at cnt=20, then 2 before 0
    for (int n = 0; n < 64; n++) begin
      blk[0][n] = 8'(n);
      blk[2][n] = 8'(n) ^ 8'h55;
    end
    @(negedge clk);
    bus.req_valid = 3'b001;
    wait_grant(g, gc);
    chk("t5_grant0", 32'(g), 32'h1);
    repeat (21) @(negedge clk);
    bus.req_valid = 3'b000;
    chk("t5_byte20", 32'(bus.sout_data), 32'h14);
    bus.req_valid = 3'b100;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.sout_valid), 0);
    chk("t5_rst_busy",  32'(bus.busy), 0);
    chk("t5_rst_data",  32'(bus.sout_data), 0);
    chk("t5_rst_rdy",   32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant(g, gc);
    chk("t5_grant2", 32'(g), 32'h4);
    recv("t5a", 2, 1'b0, 3'b101, nc);
    wait_grant(g, gc);
    chk("t5_grant0b", 32'(g), 32'h1);
    recv("t5b", 0, 1'b0, 3'b000, nc);

    // single requester granted back-to-back
    @(negedge clk);
    bus.req_valid = 3'b100;
    wait_grant(g, gc);
    chk("t6_grant_a", 32'(g), 32'h4);
    prev = gc;
    recv("t6a", 2, 1'b0, 3'b100, nc);
    wait_grant(g, gc);
    chk("t6_grant_b", 32'(g), 32'h4);
    chk("t6_spacing", gc - prev, 65);
    recv("t6b", 2, 1'b0, 3'b000, nc);
    @(negedge clk);
    chk("t6_idle_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
